// File: rtl/full_binary_adder_if.sv
// Bit-slice adder bus: the combinational operand/result bits plus the serial control inputs and the serial results.
interface full_binary_adder_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             A;
  logic             B;
  logic             C_in;
  logic             Sum;
  logic             C_out;
  logic             ser_en;
  logic             ser_start;
  logic             ser_sum;
  logic             ser_carry;
  logic [WIDTH-1:0] ser_word;
  logic [CNT_W-1:0] ser_cnt;
  logic             ser_done;

  modport master (
    output A, B, C_in, ser_en, ser_start,
    input  Sum, C_out, ser_sum, ser_carry, ser_word, ser_cnt, ser_done
  );

  modport slave (
    input  A, B, C_in, ser_en, ser_start,
    output Sum, C_out, ser_sum, ser_carry, ser_word, ser_cnt, ser_done
  );
endinterface

// File: rtl/full_binary_adder.sv
// 1-bit full adder (zero-latency Sum/C_out) plus an LSB-first serial accumulator, one bit per enabled clock.
// Serial results are registered (1 cycle); no backpressure, ser_en simply gates each step.
module full_binary_adder #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  full_binary_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             sum_q;
  logic             carry_q;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic cin_eff;
  logic s_bit;
  logic c_bit;

  // Pure combinational slice: never depends on clk, rst or serial controls.
  assign bus.Sum   = bus.A ^ bus.B ^ bus.C_in;
  assign bus.C_out = (bus.A & bus.B) | (bus.A & bus.C_in) | (bus.B & bus.C_in);

  // The first bit of a word takes C_in; later bits ride the stored carry.
  assign cin_eff = bus.ser_start ? bus.C_in : carry_q;
  assign s_bit   = bus.A ^ bus.B ^ cin_eff;
  assign c_bit   = (bus.A & bus.B) | (bus.A & cin_eff) | (bus.B & cin_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.ser_en) begin
        sum_q   <= s_bit;
        carry_q <= c_bit;
        word_q  <= {s_bit, word_q[WIDTH-1:1]};
        if (bus.ser_start) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.ser_sum   = sum_q;
  assign bus.ser_carry = carry_q;
  assign bus.ser_word  = word_q;
  assign bus.ser_cnt   = cnt_q;
  assign bus.ser_done  = done_q;
endmodule

// File: tb/tb_full_binary_adder.sv
// Directed bench: combinational sweep, then serial words checked every cycle against an arithmetic word model.
module tb_full_binary_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  full_binary_adder_if #(.WIDTH(WIDTH)) bus ();

  full_binary_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Word-level model: operand bits accumulated as integers, results read off the arithmetic total.
  int       m_acc;
  int       m_cin0;
  int       m_cnt;
  bit       m_sum;
  bit       m_carry;
  bit       m_done;
  bit [7:0] m_word;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit st,
                            input bit a, input bit b, input bit ci);
    int k;
    int total;
    if (r) begin
      m_cnt = 0; m_sum = 0; m_carry = 0; m_word = '0; m_done = 0;
      m_acc = 0; m_cin0 = 0;
      return;
    end
    m_done = 0;
    if (!en) return;
    if (st || m_cnt == 0) begin
      m_acc  = 0;
      m_cin0 = st ? int'(ci) : int'(m_carry);
      k      = 0;
    end else begin
      k = m_cnt;
    end
    m_acc   = m_acc + ((int'(a) + int'(b)) << k);
    total   = m_acc + m_cin0;
    m_sum   = bit'((total >> k) & 1);
    m_carry = bit'((total >> (k + 1)) & 1);
    m_word  = {m_sum, m_word[7:1]};
    if (st) m_cnt = 1;
    else if (k == WIDTH - 1) begin
      m_cnt  = 0;
      m_done = 1;
    end else m_cnt = k + 1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ser_done",  int'(bus.ser_done),  int'(m_done));
      chk("ser_cnt",   int'(bus.ser_cnt),   m_cnt);
      chk("ser_sum",   int'(bus.ser_sum),   int'(m_sum));
      chk("ser_carry", int'(bus.ser_carry), int'(m_carry));
      chk("ser_word",  int'(bus.ser_word),  int'(m_word));
      chk("comb_add",  int'({bus.C_out, bus.Sum}),
          int'(bus.A) + int'(bus.B) + int'(bus.C_in));
    end
  end

  task automatic apply(input bit r, input bit en, input bit st,
                       input bit a, input bit b, input bit ci);
    rst = r; bus.ser_en = en; bus.ser_start = st;
    bus.A = a; bus.B = b; bus.C_in = ci;
    @(posedge clk);
    model_step(r, en, st, a, b, ci);
    #1;
  endtask

  // Sends nbits of a word LSB-first; gaps[k] inserts an idle cycle (with a stray ser_start) after bit k.
  task automatic send_word(input bit [7:0] opa, input bit [7:0] opb, input bit ci,
                           input bit use_start, input bit [7:0] gaps, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      apply(1'b0, 1'b1, use_start && k == 0, opa[k], opb[k], ci);
      if (gaps[k]) apply(1'b0, 1'b0, 1'b1, ~opa[k], opb[k], 1'b1);
    end
  endtask

  bit [1:0] comb_exp [8];

  initial begin
    comb_exp[0] = 2'b00; comb_exp[1] = 2'b01; comb_exp[2] = 2'b01; comb_exp[3] = 2'b10;
    comb_exp[4] = 2'b01; comb_exp[5] = 2'b10; comb_exp[6] = 2'b10; comb_exp[7] = 2'b11;

    // Combinational sweep with the clocked side left undriven.
    rst = 1'bx; bus.ser_en = 1'bx; bus.ser_start = 1'bx;
    for (int i = 0; i < 8; i++) begin
      {bus.C_in, bus.B, bus.A} = 3'(i);
      #2;
      chk($sformatf("comb_%0d", i), int'({bus.C_out, bus.Sum}), int'(comb_exp[i]));
    end

    // Reset wins over an active serial enable.
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_on = 1'b1;
    chk("rst_word", int'(bus.ser_word), 0);
    chk("rst_cnt",  int'(bus.ser_cnt),  0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    send_word(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h00, 8);
    chk("lit_5a3c_done",  int'(bus.ser_done),  1);
    chk("lit_5a3c_word",  int'(bus.ser_word),  'h96);
    chk("lit_5a3c_carry", int'(bus.ser_carry), 0);

    send_word(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 8);
    chk("lit_ff01_word",  int'(bus.ser_word),  'h00);
    chk("lit_ff01_carry", int'(bus.ser_carry), 1);

    // Wrap-around: no ser_start, so the previous carry-out feeds bit 0.
    send_word(8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8);
    chk("lit_wrap_word",  int'(bus.ser_word),  'h02);
    chk("lit_wrap_carry", int'(bus.ser_carry), 0);

    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8);
    chk("lit_cin_word",  int'(bus.ser_word),  'h00);
    chk("lit_cin_carry", int'(bus.ser_carry), 1);

    send_word(8'h5A, 8'h3C, 1'b0, 1'b1, 8'b0100_1011, 8);
    chk("lit_gap_done", int'(bus.ser_done), 1);
    chk("lit_gap_word", int'(bus.ser_word), 'h96);

    // Abandon a word after four bits; the restarted word alone may complete.
    send_word(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h00, 4);
    chk("lit_restart_cnt", int'(bus.ser_cnt), 4);
    send_word(8'h3C, 8'h5A, 1'b1, 1'b1, 8'h00, 8);
    chk("lit_restart_word",  int'(bus.ser_word),  'h97);
    chk("lit_restart_carry", int'(bus.ser_carry), 0);

    // Mid-word reset: no completion for the interrupted word.
    send_word(8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 5);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("lit_midrst_cnt",  int'(bus.ser_cnt),  0);
    chk("lit_midrst_word", int'(bus.ser_word), 0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk_on = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
